multicycle_control_unit: RTL
============================

// Module: multicycle_control_unit
// PURPOSE
//  Initiator side of the ALU interface: multicycle MIPS control FSM that sequences each instruction and drives
//  ALUOperation plus datapath selects, and consumes the ALU Zero flag for branch resolution. Sits between the
//  instruction register (opcode/funct) and the shared multicycle datapath (PC, memory, IR, regfile, ALU, ALUOut).
// PARAMETERS
//  none -- ALU operation codes and opcode/funct values are fixed localparams matching the ALU decode
// PORTS
//  clk          in   1  system clock, rising edge
//  reset        in   1  asynchronous, active-low reset
//  Opcode       in   6  IR[31:26]
//  Funct        in   6  IR[5:0]
//  Zero         in   1  ALU zero flag (combinational from ALU)
//  ALUOperation out  4  AND 0000, OR 0001, NOR 0010, ADD 0011, SUB 0100, SRL 0101, SLL 0110, LUI 0111, BEQ 1000, BNE 1001
//  ALUSrcA      out  1  0 = PC, 1 = reg A
//  ALUSrcB      out  2  00 = reg B, 01 = const 4, 10 = ext imm, 11 = ext imm << 2
//  ExtOp        out  1  1 = sign-extend imm, 0 = zero-extend
//  IorD         out  1  memory address: 0 = PC, 1 = ALUOut
//  MemRead      out  1  memory read enable
//  MemWrite     out  1  memory write enable
//  IRWrite      out  1  load IR
//  RegDst       out  1  0 = rt, 1 = rd
//  MemtoReg     out  1  0 = ALUOut, 1 = MDR
//  RegWrite     out  1  register file write enable
//  PCSrc        out  2  00 = ALU result, 01 = ALUOut, 10 = jump target {PC[31:28], IR[25:0], 2'b00}
//  PCWrite      out  1  PC load enable (already includes branch qualification)
//  IllegalOp    out  1  one-cycle pulse in DECODE on unsupported opcode/funct
//  State        out  4  current state encoding, for debug/bench
// BEHAVIOUR
//  - States: RST 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, REX 7, RWB 8, IEX 9, IWB 10, BRANCH 11, JUMP 12.
//  - reset low: state <= RST asynchronously. In RST every output is 0 (ALUOperation 0000, State 0000).
//    First rising edge with reset high moves RST->FETCH. Reset mid-instruction aborts it; no partial writes.
//  - Outputs are Moore decodes of state only. Exception: PCWrite in BRANCH = Zero (combinational).
//    Any control not listed for a state is 0.
//  - FETCH: MemRead, IRWrite, IorD=0, ALUSrcA=0, ALUSrcB=01, ALU=ADD, PCSrc=00, PCWrite=1. -> DECODE.
//  - DECODE: ALUSrcA=0, ALUSrcB=11, ExtOp=1, ALU=ADD (branch target into ALUOut). Next state by Opcode:
//    lw 0x23 / sw 0x2B -> MEMADR; R 0x00 with supported funct -> REX; addi 0x08, andi 0x0C, ori 0x0D, lui 0x0F -> IEX;
//    beq 0x04, bne 0x05 -> BRANCH; j 0x02 -> JUMP; anything else -> FETCH with IllegalOp=1 (treated as NOP).
//  - MEMADR: ALUSrcA=1, ALUSrcB=10, ExtOp=1, ALU=ADD. lw -> MEMRD, sw -> MEMWR.
//  - MEMRD: MemRead, IorD=1 -> MEMWB.   MEMWB: RegDst=0, MemtoReg=1, RegWrite -> FETCH.
//  - MEMWR: MemWrite, IorD=1 -> FETCH.
//  - REX: ALUSrcA=1, ALUSrcB=00. Funct map: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x27 NOR, 0x00 SLL, 0x02 SRL. -> RWB.
//  - RWB: RegDst=1, MemtoReg=0, RegWrite -> FETCH. Unsupported funct never reaches REX (caught in DECODE).
//  - IEX: ALUSrcA=1, ALUSrcB=10. addi ADD/ExtOp=1; andi AND/ExtOp=0; ori OR/ExtOp=0; lui LUI/ExtOp=0. -> IWB.
//  - IWB: RegDst=0, MemtoReg=0, RegWrite -> FETCH.
//  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALU=BEQ (beq) or BNE (bne), PCSrc=01, PCWrite=Zero. -> FETCH.
//    The ALU returns 0 when the condition holds, so Zero=1 means taken.
//  - JUMP: PCSrc=10, PCWrite=1. -> FETCH.
//  - Cycle counts (FETCH through last state): lw 5, sw 4, R 4, I-ALU 4, beq/bne 3, j 3, illegal 2.
//  - Opcode/Funct are sampled only in DECODE/REX/IEX/BRANCH; IR is stable after FETCH, so no internal latch is required.
// TESTING
//  - reset low mid-MEMRD -> State=0, all outputs 0 immediately; release -> FETCH next edge, PCWrite=1, ALU=0011.
//  - add (Op 0x00, Funct 0x20) -> states 1,2,7,8,1; REX ALU=0011; RWB RegWrite=1, RegDst=1.
//  - lw (0x23) -> 1,2,3,4,5; MEMRD IorD=1, MemRead=1; MEMWB MemtoReg=1. sw (0x2B) -> 1,2,3,6 with MemWrite=1 in MEMWR only.
//  - beq with Zero=1 -> BRANCH ALU=1000, PCSrc=01, PCWrite=1. bne with Zero=0 -> ALU=1001, PCWrite=0.
//  - ori (0x0D) -> IEX ALU=0001, ExtOp=0, ALUSrcB=10. lui (0x0F) -> ALU=0111. j (0x02) -> JUMP PCSrc=10, PCWrite=1.
//  - Opcode 0x3F -> DECODE IllegalOp=1 for one cycle, then FETCH; no RegWrite/MemWrite asserted.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// ============================================================================
// multicycle_control_unit : multicycle MIPS control FSM driving ALU and
//                           datapath selects, resolving branches from Zero.
// Revision 1.0
// ============================================================================
`default_nettype none

module multicycle_control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic [3:0] ALUOperation,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ExtOp,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic [1:0] PCSrc,
  output logic       PCWrite,
  output logic       IllegalOp,
  output logic [3:0] State
);

  localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR  = 4'b0001, ALU_NOR = 4'b0010,
                         ALU_ADD = 4'b0011, ALU_SUB = 4'b0100, ALU_SRL = 4'b0101,
                         ALU_SLL = 4'b0110, ALU_LUI = 4'b0111, ALU_BEQ = 4'b1000,
                         ALU_BNE = 4'b1001;

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05,
                         OP_ADDI = 6'h08, OP_ANDI = 6'h0C, OP_ORI = 6'h0D,
                         OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;

  typedef enum logic [3:0] {
    S_RST = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEMADR = 4'd3, S_MEMRD = 4'd4,
    S_MEMWB = 4'd5, S_MEMWR = 4'd6, S_REX = 4'd7, S_RWB = 4'd8, S_IEX = 4'd9,
    S_IWB = 4'd10, S_BRANCH = 4'd11, S_JUMP = 4'd12
  } state_e;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_op;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       pc_write_cond;
  } ctrl_t;

  state_e state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic       r_legal;
  logic       op_legal;
  logic [3:0] r_alu;

  always_comb begin
    r_legal = 1'b1;
    r_alu   = ALU_ADD;
    case (Funct)
      6'h20:   r_alu = ALU_ADD;
      6'h22:   r_alu = ALU_SUB;
      6'h24:   r_alu = ALU_AND;
      6'h25:   r_alu = ALU_OR;
      6'h27:   r_alu = ALU_NOR;
      6'h00:   r_alu = ALU_SLL;
      6'h02:   r_alu = ALU_SRL;
      default: r_legal = 1'b0;
    endcase

    case (Opcode)
      OP_R:                                  op_legal = r_legal;
      OP_LW, OP_SW, OP_ADDI, OP_ANDI, OP_ORI,
      OP_LUI, OP_BEQ, OP_BNE, OP_J:          op_legal = 1'b1;
      default:                               op_legal = 1'b0;
    endcase

    state_d = S_FETCH;
    case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW:                      state_d = S_MEMADR;
          OP_R:                              state_d = r_legal ? S_REX : S_FETCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI:  state_d = S_IEX;
          OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
          OP_J:                              state_d = S_JUMP;
          default:                           state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = S_MEMWB;
      S_REX:    state_d = S_RWB;
      S_IEX:    state_d = S_IWB;
      default:  state_d = S_FETCH;
    endcase

    // Outputs are registered by decoding the upcoming state; IR is already
    // loaded whenever an opcode-dependent state is entered.
    ctrl_d = '0;
    case (state_d)
      S_FETCH: begin
        ctrl_d.mem_read  = 1'b1;
        ctrl_d.ir_write  = 1'b1;
        ctrl_d.alu_src_b = 2'b01;
        ctrl_d.alu_op    = ALU_ADD;
        ctrl_d.pc_write  = 1'b1;
      end
      S_DECODE: begin
        ctrl_d.alu_src_b = 2'b11;
        ctrl_d.ext_op    = 1'b1;
        ctrl_d.alu_op    = ALU_ADD;
      end
      S_MEMADR: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = 2'b10;
        ctrl_d.ext_op    = 1'b1;
        ctrl_d.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl_d.mem_read = 1'b1;
        ctrl_d.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.i_or_d    = 1'b1;
      end
      S_REX: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_op    = r_alu;
      end
      S_RWB: begin
        ctrl_d.reg_dst   = 1'b1;
        ctrl_d.reg_write = 1'b1;
      end
      S_IEX: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = 2'b10;
        case (Opcode)
          OP_ANDI: ctrl_d.alu_op = ALU_AND;
          OP_ORI:  ctrl_d.alu_op = ALU_OR;
          OP_LUI:  ctrl_d.alu_op = ALU_LUI;
          default: begin
            ctrl_d.alu_op = ALU_ADD;
            ctrl_d.ext_op = 1'b1;
          end
        endcase
      end
      S_IWB: ctrl_d.reg_write = 1'b1;
      S_BRANCH: begin
        ctrl_d.alu_src_a     = 1'b1;
        ctrl_d.alu_op        = (Opcode == OP_BNE) ? ALU_BNE : ALU_BEQ;
        ctrl_d.pc_src        = 2'b01;
        ctrl_d.pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        ctrl_d.pc_src   = 2'b10;
        ctrl_d.pc_write = 1'b1;
      end
      default: ctrl_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RST;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign ALUOperation = ctrl_q.alu_op;
  assign ALUSrcA      = ctrl_q.alu_src_a;
  assign ALUSrcB      = ctrl_q.alu_src_b;
  assign ExtOp        = ctrl_q.ext_op;
  assign IorD         = ctrl_q.i_or_d;
  assign MemRead      = ctrl_q.mem_read;
  assign MemWrite     = ctrl_q.mem_write;
  assign IRWrite      = ctrl_q.ir_write;
  assign RegDst       = ctrl_q.reg_dst;
  assign MemtoReg     = ctrl_q.mem_to_reg;
  assign RegWrite     = ctrl_q.reg_write;
  assign PCSrc        = ctrl_q.pc_src;
  // Branch qualification stays combinational: Zero is valid in the BRANCH cycle itself.
  assign PCWrite      = ctrl_q.pc_write | (ctrl_q.pc_write_cond & Zero);
  assign IllegalOp    = (state_q == S_DECODE) & ~op_legal;
  assign State        = state_q;

endmodule

`default_nettype wire
